// File: rtl/memory_word_loader_if.sv
// memory_word_loader_if: byte-stream input and memory write-port bundle for memory_word_loader
// The master side feeds bytes and start; the slave side is the loader itself.
interface memory_word_loader_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 30
);
   logic              start;
   logic              rx_valid;
   logic [7:0]        rx_byte;
   logic              rx_ready;
   logic              WR;
   logic [ADDR_W-1:0] wr_address_word;
   logic [DATA_W-1:0] wr_data_word;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] word_count;
   logic              format_err;
   modport master (
      output start, rx_valid, rx_byte,
      input  rx_ready, WR, wr_address_word, wr_data_word, busy, done, word_count, format_err
   );
   modport slave (
      input  start, rx_valid, rx_byte,
      output rx_ready, WR, wr_address_word, wr_data_word, busy, done, word_count, format_err
   );
endinterface

// File: rtl/memory_word_loader.sv
// memory_word_loader: packs a little-endian byte stream into 30-bit words and writes them
// to sequential buffer addresses 0..WORDS-1, one write strobe per word.
module memory_word_loader #(
   parameter int WORDS  = 100,
   parameter int ADDR_W = 7,
   parameter int DATA_W = 30
) (
   input logic                CLOCK_50,
   input logic                RESET,
   memory_word_loader_if.slave bus
);
   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
   state_t            state, state_n;
   logic [1:0]        idx;
   logic [23:0]       pack;
   logic [ADDR_W-1:0] addr;
   logic              accept, last_byte, last_addr, restart;
   always_comb begin
      bus.rx_ready = state == COLLECT;
      accept       = bus.rx_valid && state == COLLECT;
      last_byte    = accept && idx == 2'd3;
      last_addr    = addr == ADDR_W'(WORDS - 1);
      restart      = bus.start && (state == IDLE || state == DONE);
      state_n      = state;
      case (state)
         IDLE, DONE: state_n = restart ? COLLECT : state;
         COLLECT:    state_n = last_byte ? WRITE : COLLECT;
         WRITE:      state_n = last_addr ? DONE : COLLECT;
         default:    state_n = IDLE;
      endcase
   end
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= state_n;
   end
   // Earlier bytes shift down from the top, so after three bytes pack holds {b2,b1,b0}.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         idx                 <= '0;
         pack                <= '0;
         addr                <= '0;
         bus.WR              <= 1'b0;
         bus.wr_address_word <= '0;
         bus.wr_data_word    <= '0;
         bus.busy            <= 1'b0;
         bus.done            <= 1'b0;
         bus.word_count      <= '0;
         bus.format_err      <= 1'b0;
      end else begin
         bus.WR   <= last_byte;
         bus.busy <= state_n == COLLECT || state_n == WRITE;
         if (restart) begin
            idx            <= '0;
            addr           <= '0;
            bus.word_count <= '0;
            bus.done       <= 1'b0;
            bus.format_err <= 1'b0;
         end
         if (accept) begin
            idx  <= idx + 2'd1;
            pack <= {bus.rx_byte, pack[23:8]};
         end
         if (last_byte) begin
            bus.wr_address_word <= addr;
            bus.wr_data_word    <= DATA_W'({bus.rx_byte, pack});
            if (|bus.rx_byte[7:6]) bus.format_err <= 1'b1;
         end
         if (state == WRITE) begin
            bus.word_count <= bus.word_count + 1'b1;
            bus.done       <= last_addr;
            addr           <= last_addr ? addr : addr + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_memory_word_loader.sv
// tb_memory_word_loader: randomized stimulus against a byte-count reference model of the loader
module tb_memory_word_loader;
   localparam int WORDS = 100, ADDR_W = 7, DATA_W = 30;
   logic clk = 1'b0, rst = 1'b0;
   always #10 clk = ~clk;
   memory_word_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
   memory_word_loader #(.WORDS(WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .CLOCK_50(clk), .RESET(rst), .bus(bus)
   );
   int checks = 0, passed = 0;
   // model: loading active, a write cycle in progress, words done, sticky error, bytes accepted
   bit m_on, m_wr, m_done, m_err;
   int m_n, m_cnt, wr_seen;
   logic [31:0] m_word;

   task automatic model_clear();
      m_on = 0; m_wr = 0; m_done = 0; m_err = 0; m_n = 0; m_cnt = 0; m_word = '0;
   endtask

   // one clock: drive inputs, predict acceptance from byte counts, check registered outputs after the edge
   task automatic step(input logic s, input logic v, input logic [7:0] b);
      bit rdy, acc;
      bus.start = s; bus.rx_valid = v; bus.rx_byte = b;
      rdy = m_on && !m_wr && m_n < 4 * WORDS;
      checks++; if (bus.rx_ready !== rdy) $display("FAIL rx_ready: got %b expected %b", bus.rx_ready, rdy); else passed++;
      acc = v && rdy;
      if (m_wr) begin m_cnt++; m_done = m_cnt == WORDS; end
      m_wr = 0;
      if (s && (!m_on || m_done)) begin m_on = 1; m_n = 0; m_cnt = 0; m_done = 0; m_err = 0; end
      if (acc) begin
         m_word[8*(m_n%4) +: 8] = b;
         m_n++;
         if (m_n % 4 == 0) begin m_wr = 1; m_err = m_err || b[7:6] != 2'b00; end
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      checks++; if (bus.WR !== m_wr) $display("FAIL WR: got %b expected %b", bus.WR, m_wr); else passed++;
      if (m_wr) begin
         wr_seen++;
         checks++; if (bus.wr_address_word !== ADDR_W'(m_n/4 - 1)) $display("FAIL wr_address_word: got %0d expected %0d", bus.wr_address_word, m_n/4 - 1); else passed++;
         checks++; if (bus.wr_data_word !== m_word[29:0]) $display("FAIL wr_data_word: got %h expected %h", bus.wr_data_word, m_word[29:0]); else passed++;
      end
      checks++; if (bus.busy !== (m_on && !m_done)) $display("FAIL busy: got %b expected %b", bus.busy, m_on && !m_done); else passed++;
      checks++; if (bus.done !== m_done) $display("FAIL done: got %b expected %b", bus.done, m_done); else passed++;
      checks++; if (bus.word_count !== ADDR_W'(m_cnt)) $display("FAIL word_count: got %0d expected %0d", bus.word_count, m_cnt); else passed++;
      checks++; if (bus.format_err !== m_err) $display("FAIL format_err: got %b expected %b", bus.format_err, m_err); else passed++;
   endtask

   task automatic do_reset();
      bus.start = 1'b0; bus.rx_valid = 1'b0; bus.rx_byte = '0;
      rst = 1'b1;
      #1;
      checks++; if (bus.WR !== 1'b0) $display("FAIL reset_WR: got %b expected 0", bus.WR); else passed++;
      checks++;
      if ({bus.busy, bus.done, bus.format_err, bus.rx_ready, bus.word_count, bus.wr_address_word, bus.wr_data_word} !== '0)
         $display("FAIL reset_outputs: got busy=%b done=%b err=%b rdy=%b cnt=%0d addr=%0d data=%h expected all 0",
                  bus.busy, bus.done, bus.format_err, bus.rx_ready, bus.word_count, bus.wr_address_word, bus.wr_data_word);
      else passed++;
      model_clear();
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.rx_valid = 1'b0; bus.rx_byte = '0;
      #3 do_reset();
   endtask

   task automatic test_pack();
      step(1, 0, 8'h00);
      step(0, 1, 8'h78); step(0, 1, 8'h56); step(0, 1, 8'h34); step(0, 1, 8'h12);
      checks++; if (bus.wr_data_word !== 30'h12345678) $display("FAIL pack_data: got %h expected 12345678", bus.wr_data_word); else passed++;
      checks++; if (bus.format_err !== 1'b0) $display("FAIL pack_err: got %b expected 0", bus.format_err); else passed++;
      step(0, 0, 8'h00);
      repeat (4) step(0, 1, 8'hFF);
      checks++; if (bus.wr_data_word !== 30'h3FFFFFFF) $display("FAIL ff_data: got %h expected 3fffffff", bus.wr_data_word); else passed++;
      step(0, 0, 8'h00);
      repeat (8) step(0, 1, 8'h01);
      checks++; if (bus.format_err !== 1'b1) $display("FAIL err_sticky: got %b expected 1", bus.format_err); else passed++;
   endtask

   task automatic test_full();
      do_reset();
      wr_seen = 0;
      step(1, 0, 8'h00);
      for (int i = 0; i < 600 && m_n < 4 * WORDS; i++) step(0, 1, 8'($urandom));
      checks++; if (m_n != 4 * WORDS) $display("FAIL full_timeout: got %0d bytes expected %0d", m_n, 4 * WORDS); else passed++;
      step(0, 1, 8'($urandom));
      checks++; if (wr_seen != WORDS) $display("FAIL full_wr_pulses: got %0d expected %0d", wr_seen, WORDS); else passed++;
      checks++; if (bus.done !== 1'b1) $display("FAIL full_done: got %b expected 1", bus.done); else passed++;
      checks++; if (bus.word_count !== 7'd100) $display("FAIL full_count: got %0d expected 100", bus.word_count); else passed++;
      checks++; if (bus.wr_address_word !== 7'd99) $display("FAIL full_last_addr: got %0d expected 99", bus.wr_address_word); else passed++;
      repeat (10) step(0, 1, 8'($urandom));
      checks++; if (wr_seen != WORDS) $display("FAIL wr_after_done: got %0d expected %0d", wr_seen, WORDS); else passed++;
   endtask

   task automatic test_gapped();
      do_reset();
      step(1, 0, 8'h00);
      for (int i = 0; i < 5000 && !m_done; i++)
         step(i % 97 == 5, $urandom_range(0, 9) < 6, 8'($urandom));
      checks++; if (bus.done !== 1'b1 || !m_done) $display("FAIL gapped_timeout: got done=%b expected 1", bus.done); else passed++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      step(1, 0, 8'h00);
      for (int i = 0; i < 100 && m_n < 22; i++) step(0, 1, 8'($urandom));
      do_reset();
      step(1, 0, 8'h00);
      step(0, 1, 8'hA1); step(0, 1, 8'hB2); step(0, 1, 8'hC3); step(0, 1, 8'h04);
      checks++; if (bus.WR !== 1'b1 || bus.wr_address_word !== 7'd0) $display("FAIL restart_addr: got WR=%b addr=%0d expected WR=1 addr=0", bus.WR, bus.wr_address_word); else passed++;
      checks++; if (bus.wr_data_word !== 30'h04C3B2A1) $display("FAIL restart_data: got %h expected 04c3b2a1", bus.wr_data_word); else passed++;
      do_reset();
      repeat (3) step(0, 1, 8'h55);
   endtask

   initial begin
      model_clear();
      test_reset();
      test_pack();
      test_full();
      test_gapped();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
